vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator, successor to the fixed 640x480 sync block. It runs on the system clock with an internal pixel clock-enable divider instead of a derived clock. Timing per axis and sync polarity are configurable, and all outputs are registered and mutually aligned. It also emits a pixel strobe, line-start and frame-start pulses, and blanking flags for downstream pixel pipelines and frame-buffer readers.

Parameters:
CLK_DIV, 2, i_clk cycles per pixel (>=1); 1 means one pixel per i_clk
CNT_W, 10, width of o_x/o_y; H_TOTAL and V_TOTAL must each be <= 2^CNT_W
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of o_hsync (0 = active-low)
VSYNC_POL, 0, active level of o_vsync (0 = active-low)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
o_pix_en  output  1  pixel strobe; high in the last i_clk cycle of each pixel
o_x  output  CNT_W  horizontal position, 0..H_TOTAL-1
o_y  output  CNT_W  vertical position, 0..V_TOTAL-1
o_hsync  output  1  horizontal sync, polarity per HSYNC_POL
o_vsync  output  1  vertical sync, polarity per VSYNC_POL
o_de  output  1  display enable (active area)
o_hblank  output  1  o_x >= H_DISPLAY
o_vblank  output  1  o_y >= V_DISPLAY
o_line_start  output  1  one-cycle pulse: first i_clk cycle with o_x==0
o_frame_start  output  1  one-cycle pulse: first i_clk cycle with o_x==0 and o_y==0

Behaviour:
- Derived values: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is defined the same way (default 525). Per-axis order is display, front porch, sync, back porch.
- Clock and reset: one clock domain, i_clk. i_reset is synchronous and active-high. No derived clocks; all state changes on posedge i_clk.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1). o_pix_en = tick, decoded from registered state only. With CLK_DIV=1, tick is constant 1 out of reset.
- Counters: on a posedge with tick=1, x advances: x = (x==H_TOTAL-1) ? 0 : x+1. When x wraps, y advances: y = (y==V_TOTAL-1) ? 0 : y+1. Counters hold when tick=0.
- Registered decodes: o_hsync, o_vsync, o_de, o_hblank, o_vblank are registered from next-state counter values, so they change on the same edge as o_x/o_y. Zero skew relative to the counters.
  - hsync active iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync active iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491). vsync therefore toggles only on the edge where x wraps to 0.
  - o_de = !hblank && !vblank.
- Pulses: o_line_start / o_frame_start go high on the edge the counters enter x==0 (and y==0 for frame), for exactly one i_clk cycle regardless of CLK_DIV.
- Reset (i_reset high at a posedge, including mid-frame):
  - div_cnt=0; o_x=H_TOTAL-1; o_y=V_TOTAL-1 (last pixel of back porch).
  - o_hsync=!HSYNC_POL; o_vsync=!VSYNC_POL.
  - o_de=0; o_hblank=1; o_vblank=1; o_line_start=0; o_frame_start=0.
  - o_pix_en = (CLK_DIV==1).
  - The first tick after release moves the counters to (0,0) and raises o_frame_start and o_line_start together.
- Latency from reset release (CLK_DIV=2): cycle 0 div_cnt=0; cycle 1 tick; cycle 2 counters (0,0), o_de=1, o_frame_start=1.
- Reset has priority over tick. Reset asserted on a tick edge leaves the counters at the reset values.
- Elaboration check (generate-time error): any porch/sync/display parameter == 0, CLK_DIV < 1, or a total exceeding 2^CNT_W.

Test Plan:
- Reset release, defaults: o_frame_start and o_line_start high in cycle 2 only; o_x=0, o_y=0, o_de=1, o_hsync=1, o_vsync=1; o_pix_en pattern 0,1,0,1 from cycle 0.
- Line timing, defaults: o_hsync low for exactly 96 pixels (192 i_clk) starting at x=656. o_de high for x 0..639. Line period 1600 i_clk. o_line_start once per line.
- Frame timing, defaults: o_vsync low for y 490..491 only, transitions coincide with x 799->0. Frame period 800*525*2 = 840000 i_clk. Exactly one o_frame_start per frame.
- CLK_DIV=1, HSYNC_POL=1, VSYNC_POL=1, 800x600 params (40/128/88, 1/4/23): o_pix_en constantly 1. o_hsync high for x 840..967. Frame period 1056*628 cycles.
- Mid-frame reset at x=300, y=200 coincident with a tick: counters go to (H_TOTAL-1, V_TOTAL-1), syncs inactive, o_de=0. Restart sequence is identical to the first scenario.
- Wrap check with small params (H 4/1/1/1, V 3/1/1/1, CLK_DIV=3): full x/y sequence, o_de, o_hblank/o_vblank, and pulses match the reference model cycle-for-cycle over 3 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator. Runs on the system
//               clock. A pixel clock-enable divider advances the x/y counters.
//               Sync, blanking, display-enable and line/frame-start outputs
//               are all registered. They change on the same edge as the
//               counters.
// Ports       : i_clk          system clock
//               i_reset        synchronous, active-high reset
//               o_pix_en       pixel strobe, last i_clk cycle of each pixel
//               o_x / o_y      raster position
//               o_hsync/vsync  sync outputs, active level set by *_POL
//               o_de           display enable (active area)
//               o_hblank       o_x outside the active width
//               o_vblank       o_y outside the active height
//               o_line_start   one-cycle pulse on entry to x==0
//               o_frame_start  one-cycle pulse on entry to (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = 10,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] c_X_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_Y_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic c_HS_ON = (HSYNC_POL != 0);
    localparam logic c_VS_ON = (VSYNC_POL != 0);

    // Reject unusable timing at elaboration.
    if (CLK_DIV < 1 ||
        H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
        c_H_TOTAL > (1 << CNT_W) || c_V_TOTAL > (1 << CNT_W)) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic               r_hblank;
    logic               r_vblank;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [CNT_W-1:0]   w_x_next;
    logic [CNT_W-1:0]   w_y_next;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_hblank_next;
    logic               w_vblank_next;

    // The strobe comes from the divider register alone, so it is glitch-free.
    // With CLK_DIV==1 the counter is a constant zero and the strobe stays high.
    assign w_tick   = (r_div_cnt == c_DIV_LAST);
    assign w_x_wrap = w_tick && (r_x == c_X_LAST);
    assign w_y_wrap = w_x_wrap && (r_y == c_Y_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            w_x_next = w_x_wrap ? '0 : r_x + CNT_W'(1);
        end
        if (w_x_wrap) begin
            w_y_next = (r_y == c_Y_LAST) ? '0 : r_y + CNT_W'(1);
        end
    end

    // All decodes use the next counter values. Their registers then line up
    // with o_x/o_y with no skew.
    assign w_hs_act      = (w_x_next >= c_HS_START) && (w_x_next <= c_HS_END);
    assign w_vs_act      = (w_y_next >= c_VS_START) && (w_y_next <= c_VS_END);
    assign w_hblank_next = (w_x_next >= c_H_ACT);
    assign w_vblank_next = (w_y_next >= c_V_ACT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Park on the last back-porch pixel. The first tick then enters
            // (0,0) and raises both start pulses.
            r_div_cnt     <= '0;
            r_x           <= c_X_LAST;
            r_y           <= c_Y_LAST;
            r_hsync       <= ~c_HS_ON;
            r_vsync       <= ~c_VS_ON;
            r_de          <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= w_hs_act ? c_HS_ON : ~c_HS_ON;
            r_vsync       <= w_vs_act ? c_VS_ON : ~c_VS_ON;
            r_de          <= ~w_hblank_next & ~w_vblank_next;
            r_hblank      <= w_hblank_next;
            r_vblank      <= w_vblank_next;
            // Pulses fire only on tick edges. They last one i_clk cycle for
            // any divider setting.
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_y_wrap;
        end
    end

    assign o_pix_en      = w_tick;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_hblank      = r_hblank;
    assign o_vblank      = r_vblank;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. It runs three
//               configurations: the 640x480 default, 800x600 with
//               CLK_DIV=1 and positive syncs, and a tiny wrap-test raster.
//               It checks them against a closed-form raster model and
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic rst_t = 1'b1;

    // Default 640x480, CLK_DIV=2
    logic        w_d_pe, w_d_hs, w_d_vs, w_d_de, w_d_hb, w_d_vb, w_d_ls, w_d_fs;
    logic [9:0]  w_d_x, w_d_y;
    // 800x600, CLK_DIV=1, positive syncs
    logic        w_s_pe, w_s_hs, w_s_vs, w_s_de, w_s_hb, w_s_vb, w_s_ls, w_s_fs;
    logic [10:0] w_s_x, w_s_y;
    // Tiny raster H 4/1/1/1, V 3/1/1/1, CLK_DIV=3
    logic        w_t_pe, w_t_hs, w_t_vs, w_t_de, w_t_hb, w_t_vb, w_t_ls, w_t_fs;
    logic [3:0]  w_t_x, w_t_y;

    vga_timing_gen u_dflt (
        .i_clk(clk), .i_reset(rst_d), .o_pix_en(w_d_pe), .o_x(w_d_x), .o_y(w_d_y),
        .o_hsync(w_d_hs), .o_vsync(w_d_vs), .o_de(w_d_de), .o_hblank(w_d_hb),
        .o_vblank(w_d_vb), .o_line_start(w_d_ls), .o_frame_start(w_d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CNT_W(11),
        .H_DISPLAY(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_DISPLAY(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_svga (
        .i_clk(clk), .i_reset(rst_s), .o_pix_en(w_s_pe), .o_x(w_s_x), .o_y(w_s_y),
        .o_hsync(w_s_hs), .o_vsync(w_s_vs), .o_de(w_s_de), .o_hblank(w_s_hb),
        .o_vblank(w_s_vb), .o_line_start(w_s_ls), .o_frame_start(w_s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .CNT_W(4),
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .i_clk(clk), .i_reset(rst_t), .o_pix_en(w_t_pe), .o_x(w_t_x), .o_y(w_t_y),
        .o_hsync(w_t_hs), .o_vsync(w_t_vs), .o_de(w_t_de), .o_hblank(w_t_hb),
        .o_vblank(w_t_vb), .o_line_start(w_t_ls), .o_frame_start(w_t_fs)
    );

    // Packed sample: [31] pix_en, [30:19] x, [18:7] y,
    // [6] hsync [5] vsync [4] de [3] hblank [2] vblank [1] line_start [0] frame_start
    localparam int c_B_PE = 31;
    localparam int c_B_HS = 6;
    localparam int c_B_VS = 5;
    localparam int c_B_DE = 4;
    localparam int c_B_LS = 1;
    localparam int c_B_FS = 0;
    localparam int c_HIST = 4000;

    logic [31:0] hist [0:c_HIST-1];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec(input int dut);
        case (dut)
            0: obs_vec = {w_d_pe, 12'(w_d_x), 12'(w_d_y), w_d_hs, w_d_vs, w_d_de, w_d_hb, w_d_vb, w_d_ls, w_d_fs};
            1: obs_vec = {w_s_pe, 12'(w_s_x), 12'(w_s_y), w_s_hs, w_s_vs, w_s_de, w_s_hb, w_s_vb, w_s_ls, w_s_fs};
            default: obs_vec = {w_t_pe, 12'(w_t_x), 12'(w_t_y), w_t_hs, w_t_vs, w_t_de, w_t_hb, w_t_vb, w_t_ls, w_t_fs};
        endcase
    endfunction

    // Closed-form model. Cycle c counts from the first cycle with reset low.
    // Ticks fall on cycles with c % div == div-1, so floor(c/div) pixel steps
    // have completed before cycle c, starting from the parked last pixel.
    function automatic logic [31:0] exp_vec(input int dut, input int c);
        int div, hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, ht, vt, pos, x, y;
        logic pe, ls, fs, hsy, vsy, hbl, vbl, de;
        case (dut)
            0: begin div = 2; hd = 640; hf = 16; hs = 96;  hb = 48; vd = 480; vf = 10; vs = 2; vb = 33; hp = 0; vp = 0; end
            1: begin div = 1; hd = 800; hf = 40; hs = 128; hb = 88; vd = 600; vf = 1;  vs = 4; vb = 23; hp = 1; vp = 1; end
            default: begin div = 3; hd = 4; hf = 1; hs = 1; hb = 1; vd = 3; vf = 1; vs = 1; vb = 1; hp = 0; vp = 0; end
        endcase
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        pos = (ht * vt - 1 + c / div) % (ht * vt);
        x   = pos % ht;
        y   = pos / ht;
        pe  = ((c % div) == div - 1);
        ls  = (c >= 1) && (((c - 1) % div) == div - 1) && (x == 0);
        fs  = ls && (y == 0);
        hsy = (x >= hd + hf && x < hd + hf + hs) ? (hp != 0) : (hp == 0);
        vsy = (y >= vd + vf && y < vd + vf + vs) ? (vp != 0) : (vp == 0);
        hbl = (x >= hd);
        vbl = (y >= vd);
        de  = !hbl && !vbl;
        exp_vec = {pe, 12'(x), 12'(y), hsy, vsy, de, hbl, vbl, ls, fs};
    endfunction

    // Hand-written reset state per configuration.
    function automatic logic [31:0] rst_vec(input int dut);
        case (dut)
            0: rst_vec = {1'b0, 12'd799,  12'd524, 7'b1101100};
            1: rst_vec = {1'b1, 12'd1055, 12'd627, 7'b0001100};
            default: rst_vec = {1'b0, 12'd6, 12'd5, 7'b1101100};
        endcase
    endfunction

    task automatic set_rst(input int dut, input logic v);
        case (dut)
            0: rst_d = v;
            1: rst_s = v;
            default: rst_t = v;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record n cycles starting with the current one as cycle 0.
    task automatic capture(input int dut, input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) step();
            hist[c] = obs_vec(dut);
        end
    endtask

    task automatic check_model(input int dut, input int n, input string tag);
        for (int c = 0; c < n; c++)
            check_value($sformatf("%s cyc%0d", tag, c), hist[c], exp_vec(dut, c));
    endtask

    function automatic int count_bit(input int b, input logic v, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (hist[i][b] == v) n++;
        return n;
    endfunction

    function automatic int first_idx(input int b, input logic v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (hist[i][b] == v) return i;
        return -1;
    endfunction

    function automatic int x_at(input int i);
        if (i < 0) return -1;
        return int'(hist[i][30:19]);
    endfunction

    function automatic int ls_period(input int hi);
        int a, b;
        a = first_idx(c_B_LS, 1'b1, 0, hi);
        b = (a < 0) ? -1 : first_idx(c_B_LS, 1'b1, a + 1, hi);
        return (b < 0) ? -1 : b - a;
    endfunction

    // Reset on a tick edge at the requested position, then replay the restart.
    task automatic mid_reset(input int dut, input int wx, input int wy, input string tag);
        logic [31:0] v;
        bit found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            step();
            v = obs_vec(dut);
            if (v[c_B_PE] && v[30:19] == 12'(wx) && v[18:7] == 12'(wy)) found = 1;
        end
        check_value({tag, " reach pos"}, 32'(found), 32'd1);
        set_rst(dut, 1'b1);
        step();
        check_value({tag, " reset state"}, obs_vec(dut), rst_vec(dut));
        set_rst(dut, 1'b0);
        capture(dut, 12);
        check_model(dut, 12, {tag, " restart"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        for (int d = 0; d < 3; d++)
            check_value($sformatf("reset state dut%0d", d), obs_vec(d), rst_vec(d));

        // ---- 640x480, CLK_DIV=2 ----
        rst_d = 1'b0;
        capture(0, 3202);
        check_value("dflt pix_en c0..3", {28'd0, hist[0][c_B_PE], hist[1][c_B_PE], hist[2][c_B_PE], hist[3][c_B_PE]}, 32'b0101);
        check_value("dflt c1 pos", {20'd0, hist[1][30:19]}, 32'd799);
        check_value("dflt c2 state", hist[2], {1'b0, 12'd0, 12'd0, 7'b1110011});
        check_value("dflt c3 pulses", {30'd0, hist[3][1:0]}, 32'd0);
        check_value("dflt c4 x", {20'd0, hist[4][30:19]}, 32'd1);
        check_model(0, 3202, "dflt");
        check_value("dflt hsync low cycles line0", count_bit(c_B_HS, 1'b0, 2, 1601), 192);
        check_value("dflt hsync first x", x_at(first_idx(c_B_HS, 1'b0, 0, 3201)), 656);
        check_value("dflt de cycles", count_bit(c_B_DE, 1'b1, 0, 3201), 2560);
        check_value("dflt line_start count", count_bit(c_B_LS, 1'b1, 0, 3201), 2);
        check_value("dflt line period", ls_period(3201), 1600);
        check_value("dflt frame_start count", count_bit(c_B_FS, 1'b1, 0, 3201), 1);
        mid_reset(0, 300, 2, "dflt midframe");

        // ---- 800x600, CLK_DIV=1, positive syncs ----
        rst_s = 1'b0;
        capture(1, 2113);
        check_value("svga c1 state", hist[1], {1'b1, 12'd0, 12'd0, 7'b0010011});
        check_model(1, 2113, "svga");
        check_value("svga pix_en zero cycles", count_bit(c_B_PE, 1'b0, 0, 2112), 0);
        check_value("svga hsync high cycles", count_bit(c_B_HS, 1'b1, 0, 2112), 256);
        check_value("svga hsync first x", x_at(first_idx(c_B_HS, 1'b1, 0, 2112)), 840);
        check_value("svga de cycles", count_bit(c_B_DE, 1'b1, 0, 2112), 1600);
        check_value("svga line period", ls_period(2112), 1056);

        // ---- tiny raster, CLK_DIV=3, three frames ----
        rst_t = 1'b0;
        capture(2, 381);
        check_value("small c3 state", hist[3], {1'b0, 12'd0, 12'd0, 7'b1110011});
        check_model(2, 381, "small");
        check_value("small frame_start count", count_bit(c_B_FS, 1'b1, 0, 380), 3);
        check_value("small line_start count", count_bit(c_B_LS, 1'b1, 0, 380), 18);
        check_value("small line period", ls_period(380), 21);
        check_value("small vsync low cycles", count_bit(c_B_VS, 1'b0, 0, 380), 63);
        check_value("small hsync low cycles", count_bit(c_B_HS, 1'b0, 0, 380), 54);
        check_value("small de cycles", count_bit(c_B_DE, 1'b1, 0, 380), 108);
        begin
            int n_tr = 0;
            int n_bad = 0;
            for (int i = 1; i <= 380; i++) begin
                if (hist[i][c_B_VS] != hist[i-1][c_B_VS]) begin
                    n_tr++;
                    if (hist[i][30:19] != 12'd0 || !hist[i][c_B_LS]) n_bad++;
                end
            end
            check_value("small vsync transitions", n_tr, 6);
            check_value("small vsync off-wrap transitions", n_bad, 0);
        end
        mid_reset(2, 2, 1, "small midframe");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
